// File: rtl/axi4_lite_rd_burst.sv
// Read-burst sequencer: turns one (address, length) command into consecutive single-word reads
// and buffers the returned words in a FIFO, throttling issue so the FIFO never overflows.
module axi4_lite_rd_burst #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic [31:0]      rd_addr,
    output logic             rd_valid,
    input  logic             rd_ready,
    input  logic [31:0]      rd_data,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StHold  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [31:0]      rd_addr_q;
    logic             rd_valid_q;
    logic             done_q, done_d;
    logic             push, pop;
    logic             last_word;

    logic [31:0]      mem_data [DEPTH];
    logic             mem_last [DEPTH];

    assign push      = (state_q == StIssue) && rd_ready;
    assign pop       = out_valid && out_ready;
    assign last_word = (remain_q == LEN_W'(1));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (PTR_W+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (PTR_W+1)'(1);
        end
    end

    // count never exceeds DEPTH, so its MSB alone flags a full FIFO
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d   = {cmd_addr[31:2], 2'b00};
                        remain_d = cmd_len;
                        state_d  = count_d[PTR_W] ? StHold : StIssue;
                    end
                end
            end
            StIssue: begin
                if (rd_ready) begin
                    addr_d   = addr_q + 32'd4;
                    remain_d = remain_q - LEN_W'(1);
                    if (last_word) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (count_d[PTR_W]) begin
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (!count_d[PTR_W]) begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            remain_q   <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            count_q    <= count_d;
            rd_addr_q  <= addr_d;
            rd_valid_q <= (state_d == StIssue);
            done_q     <= done_d;
            if (push) begin
                wptr_q <= wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr_q] <= rd_data;
            mem_last[wptr_q] <= last_word;
        end
    end

    assign cmd_ready = (state_q == StIdle);
    assign busy      = !cmd_ready;
    assign rd_addr   = rd_addr_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_data[rptr_q] : 32'd0;
    assign out_last  = out_valid ? mem_last[rptr_q] : 1'b0;

endmodule

// File: tb/tb_axi4_lite_rd_burst.sv
// Directed bench for axi4_lite_rd_burst with a 4-cycle read-master model returning addr^0xA5A5A5A5.
module tb_axi4_lite_rd_burst;

    localparam logic [31:0] XMASK = 32'hA5A5A5A5;

    logic        clk;
    logic        arst_n;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] rd_addr;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    logic [31:0] req_addr [$];
    logic [31:0] pop_data [$];
    logic        pop_last [$];
    int          done_cnt;
    int          mcnt;

    axi4_lite_rd_burst #(.DEPTH(8), .LEN_W(8)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read master: acks with a one-cycle rd_ready on the 4th edge after a request appears
    initial begin
        rd_ready = 1'b0;
        rd_data  = 32'd0;
        mcnt     = 0;
    end
    always begin
        @(posedge clk);
        #1;
        if (!arst_n) begin
            rd_ready = 1'b0;
            mcnt     = 0;
        end else if (rd_ready) begin
            rd_ready = 1'b0;
            mcnt     = rd_valid ? 1 : 0;
        end else if (rd_valid) begin
            mcnt = mcnt + 1;
            if (mcnt == 4) begin
                rd_ready = 1'b1;
                rd_data  = rd_addr ^ XMASK;
            end
        end
    end

    initial done_cnt = 0;
    always @(negedge clk) begin
        if (rd_ready) req_addr.push_back(rd_addr);
        if (out_valid && out_ready) begin
            pop_data.push_back(out_data);
            pop_last.push_back(out_last);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && req_addr.size() < target; i++) tick();
        check(tag, 32'(req_addr.size()), 32'(target));
    endtask

    task automatic wait_pop(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && pop_data.size() < target; i++) tick();
        check(tag, 32'(pop_data.size()), 32'(target));
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget && done_cnt < target; i++) tick();
        check(tag, 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rb;
        int pb;
        int db;
        int n;
        bit got;
        logic [31:0] exp_d [3];
        vectors     = 0;
        miscompares = 0;

        // Reset with a command already pending
        arst_n    = 1'b0;
        cmd_addr  = 32'h0000_1000;
        cmd_len   = 8'd3;
        cmd_valid = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_addr", rd_addr, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);

        // 3-word burst, accepted on the first edge after release
        arst_n = 1'b1;
        tick();
        check("len3_busy_after_accept", 32'(busy), 32'd1);
        check("len3_rd_valid_rise", 32'(rd_valid), 32'd1);
        check("len3_first_addr", rd_addr, 32'h0000_1000);
        cmd_valid = 1'b0;
        n   = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
        check("len3_accept_to_done", 32'(n), 32'd13);
        check("len3_idle_at_done", 32'(busy), 32'd0);
        repeat (3) tick();
        check("len3_done_pulses", 32'(done_cnt), 32'd1);
        check("len3_req_count", 32'(req_addr.size()), 32'd3);
        check("len3_addr0", req_addr[0], 32'h0000_1000);
        check("len3_addr1", req_addr[1], 32'h0000_1004);
        check("len3_addr2", req_addr[2], 32'h0000_1008);
        check("len3_pop_count", 32'(pop_data.size()), 32'd3);
        exp_d[0] = 32'hA5A5_B5A5;
        exp_d[1] = 32'hA5A5_B5A1;
        exp_d[2] = 32'hA5A5_B5AD;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("len3_data%0d", i), pop_data[i], exp_d[i]);
            check($sformatf("len3_last%0d", i), 32'(pop_last[i]), (i == 2) ? 32'd1 : 32'd0);
        end

        // Zero-length command
        rb = req_addr.size();
        cmd_addr  = 32'h0000_5000;
        cmd_len   = 8'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        check("len0_done_drop", 32'(done), 32'd0);
        repeat (8) tick();
        check("len0_no_reads", 32'(req_addr.size()), 32'(rb));

        // Stalled consumer: FIFO fills, issue stops at 8
        rb = req_addr.size();
        pb = pop_data.size();
        db = done_cnt;
        out_ready = 1'b0;
        cmd_addr  = 32'h0000_2000;
        cmd_len   = 8'd12;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_req(rb + 8, 200, "stall_fill8");
        repeat (20) tick();
        check("stall_reads_8", 32'(req_addr.size()), 32'(rb + 8));
        check("stall_rd_valid_low", 32'(rd_valid), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_head", out_data, 32'h0000_2000 ^ XMASK);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (20) tick();
        check("stall_one_more_read", 32'(req_addr.size()), 32'(rb + 9));
        check("stall_rd_valid_low2", 32'(rd_valid), 32'd0);
        out_ready = 1'b1;
        wait_pop(pb + 12, 400, "stall_all_popped");
        tick();
        check("stall_done_once", 32'(done_cnt), 32'(db + 1));
        for (int i = 0; i < 12; i++) begin
            check($sformatf("stall_data%0d", i), pop_data[pb + i], (32'h0000_2000 + 32'(4 * i)) ^ XMASK);
            check($sformatf("stall_last%0d", i), 32'(pop_last[pb + i]), (i == 11) ? 32'd1 : 32'd0);
        end

        // Address wrap at the top of the space
        rb = req_addr.size();
        pb = pop_data.size();
        db = done_cnt;
        cmd_addr  = 32'hFFFF_FFFC;
        cmd_len   = 8'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_done(db + 1, 60, "wrap_done");
        repeat (3) tick();
        check("wrap_req_count", 32'(req_addr.size()), 32'(rb + 2));
        check("wrap_addr0", req_addr[rb], 32'hFFFF_FFFC);
        check("wrap_addr1", req_addr[rb + 1], 32'h0000_0000);
        check("wrap_data0", pop_data[pb], 32'h5A5A_5A59);
        check("wrap_data1", pop_data[pb + 1], 32'hA5A5_A5A5);
        check("wrap_last1", 32'(pop_last[pb + 1]), 32'd1);

        // Reset in ISSUE with 3 words buffered
        rb = req_addr.size();
        out_ready = 1'b0;
        cmd_addr  = 32'h0000_3000;
        cmd_len   = 8'd5;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_req(rb + 3, 60, "midrst_three_reads");
        repeat (2) tick();
        check("midrst_pre_out_valid", 32'(out_valid), 32'd1);
        check("midrst_pre_rd_valid", 32'(rd_valid), 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_out_data", out_data, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        arst_n = 1'b1;
        tick();
        check("midrst_fifo_empty", 32'(out_valid), 32'd0);
        pb = pop_data.size();
        db = done_cnt;
        out_ready = 1'b1;
        cmd_addr  = 32'h0000_0040;
        cmd_len   = 8'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        wait_pop(pb + 1, 60, "post_rst_pop");
        tick();
        check("post_rst_done", 32'(done_cnt), 32'(db + 1));
        check("post_rst_data", pop_data[pb], 32'hA5A5_A5E5);
        check("post_rst_last", 32'(pop_last[pb]), 32'd1);
        check("post_rst_single", 32'(pop_data.size()), 32'(pb + 1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
